ov7670_config_seq: RTL and testbench
====================================

OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

Interface
REQ-001 Parameter DELAY_CYCLES, default 1_000_000, is the number of clk cycles held for a delay entry (10 ms at 100 MHz).
REQ-002 Parameter ROM_LAT, default 1, is the number of cycles from rom_addr change to a valid rom_dout.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 Port start, input, 1 bit: level or pulse; a high value sampled in IDLE begins a configuration run.
REQ-006 Port rom_addr, output, 8 bits: configuration ROM address.
REQ-007 Port rom_dout, input, 16 bits: ROM entry, {reg[15:8], value[7:0]}; 16'hFFFF marks end of table, 16'hFFF0 marks a delay.
REQ-008 Port sccb_ready, input, 1 bit: high while the SCCB transmitter is idle and can accept a write.
REQ-009 Port sccb_start, output, 1 bit: single-cycle write request to the SCCB transmitter.
REQ-010 Port sccb_reg, output, 8 bits: register address; held stable from sccb_start until sccb_ready returns high.
REQ-011 Port sccb_data, output, 8 bits: register value; held stable like sccb_reg.
REQ-012 Port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-013 Port done, output, 1 bit: high while in DONE.
REQ-014 Port wr_count, output, 8 bits: number of SCCB writes issued in the current run.

Function
REQ-015 States: IDLE, FETCH, DECODE, SEND, WAIT_TX, DELAY, DONE.
REQ-016 IDLE -> FETCH when start=1: rom_addr<=0, wr_count<=0.
REQ-017 FETCH waits exactly ROM_LAT+1 cycles after rom_addr is updated, then latches rom_dout into an internal entry register and goes to DECODE.
REQ-018 DECODE on 16'hFFFF goes to DONE; no write is issued for this entry.
REQ-019 DECODE on 16'hFFF0 loads the delay counter with DELAY_CYCLES-1 and goes to DELAY; no write is issued.
REQ-020 DECODE on any other entry loads sccb_reg/sccb_data from entry[15:8]/entry[7:0] and goes to SEND.
REQ-021 SEND drives sccb_start=1 for exactly one cycle, only in a cycle where sccb_ready=1; it waits in SEND while sccb_ready=0.
REQ-022 In the sccb_start cycle, wr_count increments (wraps 255->0) and the FSM goes to WAIT_TX.
REQ-023 WAIT_TX ignores sccb_ready for the first cycle after sccb_start, then waits for sccb_ready=1.
REQ-024 On leaving WAIT_TX, rom_addr increments and the FSM goes to FETCH.
REQ-025 DELAY decrements its counter each cycle; at 0 it increments rom_addr and goes to FETCH; total DELAY residency is DELAY_CYCLES cycles.
REQ-026 Address guard: if an entry at rom_addr=255 is processed without an end marker, the FSM goes to DONE after that entry instead of wrapping rom_addr.
REQ-027 DONE holds until start is low for at least one cycle and then high again; that rising start returns to FETCH with rom_addr=0 and wr_count=0 (re-run).
REQ-028 start is ignored in every state other than IDLE and DONE.
REQ-029 sccb_start never asserts outside SEND; at most one write is outstanding at a time.

Reset
REQ-030 While rst=0 at a clock edge, the FSM goes to IDLE and all outputs are driven to 0: rom_addr, sccb_start, sccb_reg, sccb_data, busy, done, wr_count; the delay and FETCH counters also clear.
REQ-031 A reset in any state, including mid-DELAY or WAIT_TX, aborts the run; the block does not resume, and a new start is required.

Verification
REQ-032 Table {0:1280, 1:1204, 2:FFFF}, sccb_ready tied 1 except 10 cycles low after each start, plus start pulse -> two writes (12/80, 12/04), wr_count=2, done=1, rom_addr=2.
REQ-033 Table {0:1280, 1:FFF0, 2:1100, 3:FFFF} with DELAY_CYCLES=50 -> the second sccb_start occurs at least 50 cycles after the first write completes; wr_count=2.
REQ-034 sccb_ready held 0 for 200 cycles when a write is due -> sccb_start stays 0 and sccb_reg/sccb_data stay stable; exactly one start pulse follows ready going high.
REQ-035 Table of 256 non-marker entries -> 256 writes, wr_count=0 (wrapped), done=1, rom_addr=255.
REQ-036 rst=0 asserted mid-DELAY -> next cycle all outputs are 0 and the state is IDLE; start then re-runs from rom_addr=0.
REQ-037 In DONE, start held high -> no re-run; start low then high -> full re-run with identical write sequence.

Source files
------------

// File: rtl/ov7670_config_seq_if.sv
// Bundles the configuration ROM port and the SCCB transmitter handshake
// that the OV7670 configuration sequencer drives.
interface ov7670_config_seq_if;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sccb_ready;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;

    modport master (
        output rom_addr,
        input  rom_dout,
        input  sccb_ready,
        output sccb_start,
        output sccb_reg,
        output sccb_data
    );

    modport slave (
        input  rom_addr,
        output rom_dout,
        output sccb_ready,
        input  sccb_start,
        input  sccb_reg,
        input  sccb_data
    );
endinterface

// File: rtl/ov7670_config_seq.sv
// Walks a register/value ROM and issues one SCCB write per entry, honouring
// end-of-table (FFFF) and delay (FFF0) markers.
module ov7670_config_seq #(
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int ROM_LAT      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    ov7670_config_seq_if.master        bus,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 wr_count
);
    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int FW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, SEND, WAIT_TX, DELAY, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    data_q, data_d;
    logic [15:0]   entry_q, entry_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [FW-1:0] fetch_q, fetch_d;
    logic          tx_first_q, tx_first_d;
    logic          rearm_q, rearm_d;
    logic          advance;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            entry_q    <= '0;
            delay_q    <= '0;
            fetch_q    <= '0;
            tx_first_q <= 1'b0;
            rearm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            entry_q    <= entry_d;
            delay_q    <= delay_d;
            fetch_q    <= fetch_d;
            tx_first_q <= tx_first_d;
            rearm_q    <= rearm_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        count_d        = count_q;
        reg_d          = reg_q;
        data_d         = data_q;
        entry_d        = entry_q;
        delay_d        = delay_q;
        fetch_d        = fetch_q;
        tx_first_d     = tx_first_q;
        rearm_d        = rearm_q;
        advance        = 1'b0;
        bus.sccb_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    addr_d  = '0;
                    count_d = '0;
                    fetch_d = '0;
                end
            end
            FETCH: begin
                if (fetch_q == FW'(ROM_LAT)) begin
                    entry_d = bus.rom_dout;
                    fetch_d = '0;
                    state_d = DECODE;
                end else begin
                    fetch_d = fetch_q + FW'(1);
                end
            end
            DECODE: begin
                if (entry_q == 16'hFFFF) begin
                    rearm_d = 1'b0;
                    state_d = DONE;
                end else if (entry_q == 16'hFFF0) begin
                    delay_d = DW'(DELAY_CYCLES - 1);
                    state_d = DELAY;
                end else begin
                    reg_d   = entry_q[15:8];
                    data_d  = entry_q[7:0];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.sccb_ready) begin
                    bus.sccb_start = 1'b1;
                    count_d        = count_q + 8'd1;
                    tx_first_d     = 1'b1;
                    state_d        = WAIT_TX;
                end
            end
            // The transmitter may still show ready in the cycle right after
            // the request, so that first cycle is not trusted.
            WAIT_TX: begin
                if (tx_first_q) begin
                    tx_first_d = 1'b0;
                end else if (bus.sccb_ready) begin
                    advance = 1'b1;
                end
            end
            DELAY: begin
                if (delay_q == '0) begin
                    advance = 1'b1;
                end else begin
                    delay_d = delay_q - DW'(1);
                end
            end
            DONE: begin
                if (start && rearm_q) begin
                    state_d = FETCH;
                    addr_d  = '0;
                    count_d = '0;
                    fetch_d = '0;
                end else if (!start) begin
                    rearm_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Last ROM slot without an end marker finishes the run instead of wrapping.
        if (advance) begin
            if (addr_q == 8'hFF) begin
                rearm_d = 1'b0;
                state_d = DONE;
            end else begin
                addr_d  = addr_q + 8'd1;
                fetch_d = '0;
                state_d = FETCH;
            end
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.sccb_reg  = reg_q;
    assign bus.sccb_data = data_q;
    assign wr_count      = count_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
endmodule

// File: tb/tb_ov7670_config_seq.sv
// Scoreboard bench for ov7670_config_seq: a ROM and SCCB model around the DUT,
// expected writes queued by the stimulus and popped by a monitor.
module tb_ov7670_config_seq;
    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] wr_count;

    ov7670_config_seq_if bus();

    ov7670_config_seq #(.DELAY_CYCLES(50), .ROM_LAT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count)
    );

    logic [15:0] rom [256];
    logic [15:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          tx_cnt = 0;
    logic        ready_block = 1'b0;
    int          start_count = 0;
    int          prev_start_cycle = 0;
    int          last_start_cycle = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

    // SCCB model: busy for 10 cycles after every accepted write.
    always @(posedge clk) begin
        if (bus.sccb_start === 1'b1) tx_cnt <= 10;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign bus.sccb_ready = (tx_cnt == 0) && !ready_block;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (bus.sccb_start === 1'b1) begin
            start_count++;
            prev_start_cycle = last_start_cycle;
            last_start_cycle = cycle;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual=%02h%02h required=none", bus.sccb_reg, bus.sccb_data);
            end else begin
                checkOutput("write", {16'h0, bus.sccb_reg, bus.sccb_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic waitDone(input int maxc, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_done"}, {31'h0, done}, 32'h1);
    endtask

    initial begin
        int   snap;
        int   gap;
        logic hold_ok;

        rst = 1'b0;
        start = 1'b0;
        clearRom();
        repeat (3) @(negedge clk);
        checkOutput("rst_rom_addr", {24'h0, bus.rom_addr}, 32'h0);
        checkOutput("rst_sccb_start", {31'h0, bus.sccb_start}, 32'h0);
        checkOutput("rst_sccb_reg", {24'h0, bus.sccb_reg}, 32'h0);
        checkOutput("rst_sccb_data", {24'h0, bus.sccb_data}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_wr_count", {24'h0, wr_count}, 32'h0);
        rst = 1'b1;

        $display("[TB] basic two-write table");
        clearRom();
        rom[0] = 16'h1280; rom[1] = 16'h1204;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
        applyStimulus();
        waitDone(500, "basic");
        checkOutput("basic_wr_count", {24'h0, wr_count}, 32'h2);
        checkOutput("basic_rom_addr", {24'h0, bus.rom_addr}, 32'h2);
        checkOutput("basic_busy", {31'h0, busy}, 32'h0);
        checkOutput("basic_drained", exp_q.size(), 32'h0);

        $display("[TB] start held high in DONE, then re-run");
        applyReset();
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
        waitDone(500, "level");
        snap = start_count;
        repeat (30) @(negedge clk);
        checkOutput("level_hold_done", {31'h0, done}, 32'h1);
        checkOutput("level_no_rerun", start_count, snap);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
        @(negedge clk);
        checkOutput("rerun_busy", {31'h0, busy}, 32'h1);
        checkOutput("rerun_rom_addr", {24'h0, bus.rom_addr}, 32'h0);
        checkOutput("rerun_wr_count_clear", {24'h0, wr_count}, 32'h0);
        start = 1'b0;
        waitDone(500, "rerun");
        checkOutput("rerun_wr_count", {24'h0, wr_count}, 32'h2);
        checkOutput("rerun_drained", exp_q.size(), 32'h0);

        $display("[TB] ready held low while a write is pending");
        applyReset();
        clearRom();
        rom[0] = 16'h1234;
        ready_block = 1'b1;
        snap = start_count;
        exp_q.push_back(16'h1234);
        applyStimulus();
        repeat (10) @(negedge clk);
        hold_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.sccb_start !== 1'b0 || bus.sccb_reg !== 8'h12 || bus.sccb_data !== 8'h34) hold_ok = 1'b0;
        end
        checkOutput("hold_stable", {31'h0, hold_ok}, 32'h1);
        checkOutput("hold_no_start", start_count, snap);
        checkOutput("hold_busy", {31'h0, busy}, 32'h1);
        ready_block = 1'b0;
        waitDone(500, "hold");
        checkOutput("hold_one_start", start_count, snap + 1);
        checkOutput("hold_wr_count", {24'h0, wr_count}, 32'h1);

        $display("[TB] delay entry between writes");
        applyReset();
        clearRom();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1100;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
        applyStimulus();
        waitDone(1000, "delay");
        gap = last_start_cycle - prev_start_cycle;
        checks++;
        if (gap < 61) begin
            errors++;
            $display("[TB] FAIL delay_gap actual=%0d required>=61", gap);
        end
        checkOutput("delay_wr_count", {24'h0, wr_count}, 32'h2);
        checkOutput("delay_drained", exp_q.size(), 32'h0);

        $display("[TB] full 256-entry table");
        applyReset();
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'(i), 8'(i) ^ 8'h5A};
            exp_q.push_back({8'(i), 8'(i) ^ 8'h5A});
        end
        applyStimulus();
        waitDone(10000, "full");
        checkOutput("full_wr_count", {24'h0, wr_count}, 32'h0);
        checkOutput("full_rom_addr", {24'h0, bus.rom_addr}, 32'hFF);
        checkOutput("full_drained", exp_q.size(), 32'h0);

        $display("[TB] reset in the middle of a delay");
        applyReset();
        clearRom();
        rom[0] = 16'hFFF0; rom[1] = 16'h1100;
        applyStimulus();
        repeat (20) @(negedge clk);
        checkOutput("mid_delay_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_rom_addr", {24'h0, bus.rom_addr}, 32'h0);
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_done", {31'h0, done}, 32'h0);
        checkOutput("abort_sccb_start", {31'h0, bus.sccb_start}, 32'h0);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("abort_stays_idle", {30'h0, busy, done}, 32'h0);
        exp_q.push_back(16'h1100);
        applyStimulus();
        waitDone(1000, "after_abort");
        checkOutput("after_abort_wr_count", {24'h0, wr_count}, 32'h1);
        checkOutput("after_abort_rom_addr", {24'h0, bus.rom_addr}, 32'h2);
        checkOutput("after_abort_drained", exp_q.size(), 32'h0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
